// File: rtl/fifo_pkg.sv
// Shared constants and sizing helpers for the parametrised FIFO family.
//   FIFO_ADDR_W(depth) : pointer width for a power-of-two depth (min 1)
//   FIFO_CNT_W(depth)  : occupancy counter width, wide enough to hold DEPTH
package fifo_pkg;

  localparam int FIFO_DATA_W_DEF = 32;
  localparam int FIFO_DEPTH_DEF  = 16;

  function automatic int FIFO_ADDR_W(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int FIFO_CNT_W(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_dp_mem.sv
// Simple dual-port storage array, DEPTH x DATA_W.
//   gclk  : write clock
//   we    : write enable, waddr/wdata written on rising edge
//   raddr : asynchronous read address, rdata follows combinationally
// Contents are intentionally not reset.
module fifo_dp_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              gclk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge gclk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with optional first-word-fall-through read.
//   Clk/Rst        : rising-edge clock, async active-low reset
//   EN             : global enable (push/pop and sticky flags only move when 1)
//   CLR            : synchronous flush, works regardless of EN
//   WR/dataIn      : push request and data
//   RD/dataOut     : pop request and read data
//   EMPTY/FULL/ALMOST_EMPTY/ALMOST_FULL/COUNT : registered occupancy status
//   OVERFLOW/UNDERFLOW : sticky refused-push / refused-pop flags
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W   = FIFO_DATA_W_DEF,
  parameter int DEPTH    = FIFO_DEPTH_DEF,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2,
  parameter bit FWFT     = 1'b0
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic                        EN,
  input  logic                        CLR,
  input  logic                        WR,
  input  logic [DATA_W-1:0]           dataIn,
  input  logic                        RD,
  output logic [DATA_W-1:0]           dataOut,
  output logic                        EMPTY,
  output logic                        FULL,
  output logic                        ALMOST_EMPTY,
  output logic                        ALMOST_FULL,
  output logic [FIFO_CNT_W(DEPTH)-1:0] COUNT,
  output logic                        OVERFLOW,
  output logic                        UNDERFLOW
);

  localparam int ADDR_W = FIFO_ADDR_W(DEPTH);
  localparam int CNT_W  = FIFO_CNT_W(DEPTH);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("param_sync_fifo: DEPTH must be a power of two >= 2");
  end
  if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_bad_af
    $error("param_sync_fifo: AF_LEVEL out of range 1..DEPTH");
  end
  if ((AE_LEVEL < 0) || (AE_LEVEL > DEPTH - 1)) begin : g_bad_ae
    $error("param_sync_fifo: AE_LEVEL out of range 0..DEPTH-1");
  end

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [DATA_W-1:0] mem_rdata;
  logic              act, push_ok, pop_ok;

  // Pop never bypasses from the write port, so a full FIFO can only accept
  // a push when a real entry leaves in the same cycle.
  assign act     = EN & ~CLR;
  assign pop_ok  = act & RD & ~EMPTY;
  assign push_ok = act & WR & (~FULL | pop_ok);

  always_comb begin
    cnt_nxt = COUNT;
    if (CLR)                    cnt_nxt = '0;
    else if (push_ok & ~pop_ok) cnt_nxt = COUNT + CNT_W'(1);
    else if (pop_ok & ~push_ok) cnt_nxt = COUNT - CNT_W'(1);
  end

  fifo_dp_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .gclk  (Clk),
    .we    (push_ok),
    .waddr (wr_ptr),
    .wdata (dataIn),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  // Status flags are registered from next-state occupancy so they line up
  // with COUNT in the cycle after each edge.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      COUNT        <= '0;
      EMPTY        <= 1'b1;
      FULL         <= 1'b0;
      ALMOST_EMPTY <= 1'b1;
      ALMOST_FULL  <= 1'b0;
      OVERFLOW     <= 1'b0;
      UNDERFLOW    <= 1'b0;
    end else begin
      COUNT        <= cnt_nxt;
      EMPTY        <= (cnt_nxt == '0);
      FULL         <= (cnt_nxt == DEPTH_C);
      ALMOST_EMPTY <= (cnt_nxt <= AE_C);
      ALMOST_FULL  <= (cnt_nxt >= AF_C);
      if (CLR) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        OVERFLOW  <= 1'b0;
        UNDERFLOW <= 1'b0;
      end else begin
        // Power-of-two depth: pointers wrap by plain overflow.
        if (push_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
        if (pop_ok)  rd_ptr <= rd_ptr + ADDR_W'(1);
        if (EN & WR & FULL & ~pop_ok) OVERFLOW  <= 1'b1;
        if (EN & RD & EMPTY)          UNDERFLOW <= 1'b1;
      end
    end
  end

  if (FWFT) begin : g_fwft
    // Head entry shown directly; a word pushed into an empty FIFO appears
    // once EMPTY drops after the write edge.
    assign dataOut = EMPTY ? '0 : mem_rdata;
  end else begin : g_reg
    logic [DATA_W-1:0] dout_q;
    always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst)        dout_q <= '0;
      else if (CLR)    dout_q <= '0;
      else if (pop_ok) dout_q <= mem_rdata;
    end
    assign dataOut = dout_q;
  end

endmodule
